// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control stage and the display driver:
// mode-FSM encoding and BCD digit limits.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_ADJ  = 2'd2
    } state_t;

    localparam int BCD_ONES_MAX     = 9;  // highest value of any ones digit
    localparam int SEC_TENS_MAX_DEF = 5;  // seconds wrap after 59
    localparam int MIN_TENS_MAX_DEF = 9;  // minutes wrap after 99

endpackage

// File: rtl/stopwatch_ctrl_bcd_field_counter.sv
// Two-digit BCD field counter (tens:ones) with synchronous clear.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance the field by one on this edge
//   clr        : synchronous clear to 00, overrides inc
//   tens, ones : registered BCD digits
//   wrap       : field is at TENS_MAX:ONES_MAX, so the next inc wraps to 00
module bcd_field_counter #(
    parameter int TENS_MAX = 5,
    parameter int ONES_MAX = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       wrap
);

    assign wrap = (tens == 4'(TENS_MAX)) && (ones == 4'(ONES_MAX));

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            if (wrap) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (ones == 4'(ONES_MAX)) begin
                tens <= tens + 4'd1;
                ones <= 4'd0;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: STOP/RUN/ADJ mode FSM and MM:SS BCD time keeping.
// Inputs are debounced, clk-synchronous levels plus 1 Hz / 2 Hz tick enables.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   tick_1hz              : count enable in RUN
//   tick_2hz              : adjust-increment and blink enable in ADJ
//   pause_btn             : rising edge toggles STOP/RUN
//   clear_btn             : synchronous clear to 00:00 / STOP (highest priority)
//   adj_sw                : enter/stay in ADJ while high
//   sel_sw                : adjust field select, 0 = minutes, 1 = seconds
//   min_tens..sec_ones    : registered BCD digits
//   running               : 1 while in RUN
//   blank_min, blank_sec  : blink strobes for the field being adjusted
//   rollover              : one-clk pulse on 99:59 -> 00:00 while running
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int MAX_MIN_TENS = MIN_TENS_MAX_DEF,
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_btn,
    input  logic       clear_btn,
    input  logic       adj_sw,
    input  logic       sel_sw,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       rollover
);

    state_t state, state_next;
    logic   pause_prev;
    logic   pause_edge;
    logic   blink_q, blink_next;
    logic   count_en, adj_en;
    logic   sec_inc, min_inc;
    logic   sec_wrap, min_wrap;

    assign pause_edge = pause_btn & ~pause_prev;

    // Both enables look at the pre-update state: a tick on the edge that stops
    // the watch still counts, one on the edge that starts it does not.
    assign count_en = ~clear_btn & (state == ST_RUN) & tick_1hz;
    assign adj_en   = ~clear_btn & (state == ST_ADJ) & tick_2hz;

    // Carry from seconds into minutes only while counting; adjust has no carry.
    assign sec_inc = count_en | (adj_en & sel_sw);
    assign min_inc = (count_en & sec_wrap) | (adj_en & ~sel_sw);

    bcd_field_counter #(
        .TENS_MAX (SEC_TENS_MAX),
        .ONES_MAX (BCD_ONES_MAX)
    ) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sec_inc),
        .clr   (clear_btn),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .wrap  (sec_wrap)
    );

    bcd_field_counter #(
        .TENS_MAX (MAX_MIN_TENS),
        .ONES_MAX (BCD_ONES_MAX)
    ) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (min_inc),
        .clr   (clear_btn),
        .tens  (min_tens),
        .ones  (min_ones),
        .wrap  (min_wrap)
    );

    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_next = state;
        blink_next = blink_q;
        if (clear_btn) begin
            state_next = ST_STOP;
            blink_next = 1'b0;
        end else begin
            if (adj_sw) begin
                state_next = ST_ADJ;
            end else begin
                case (state)
                    ST_ADJ:  state_next = ST_STOP;  // ADJ never resumes RUN
                    ST_STOP: if (pause_edge) state_next = ST_RUN;
                    ST_RUN:  if (pause_edge) state_next = ST_STOP;
                    default: state_next = ST_STOP;
                endcase
            end
            if (state == ST_ADJ && tick_2hz) begin
                blink_next = ~blink_q;
            end
            if (state_next != ST_ADJ) begin
                blink_next = 1'b0;
            end
        end
    end

    // Status outputs are registered from the post-edge state so they line up
    // with the digits loaded on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_STOP;
            pause_prev <= 1'b0;
            blink_q    <= 1'b0;
            rollover   <= 1'b0;
            running    <= 1'b0;
            blank_min  <= 1'b0;
            blank_sec  <= 1'b0;
        end else begin
            state      <= state_next;
            pause_prev <= pause_btn;
            blink_q    <= blink_next;
            rollover   <= count_en & sec_wrap & min_wrap;
            running    <= (state_next == ST_RUN);
            blank_min  <= (state_next == ST_ADJ) & ~sel_sw & blink_next;
            blank_sec  <= (state_next == ST_ADJ) &  sel_sw & blink_next;
        end
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Stopwatch control and time-keeping stage directly downstream of the button debouncers. It consumes debounced, clk-synchronous button/switch levels and 1 Hz / 2 Hz tick enables, and runs a STOP/RUN/ADJ mode FSM. It maintains an MM:SS count as four BCD digits and drives the display driver, including per-field blank strobes for adjust-mode blinking.

Parameters:
MAX_MIN_TENS, 9, highest minutes-tens digit; minutes wrap after MAX_MIN_TENS9 (default 99)
SEC_TENS_MAX, 5, highest seconds-tens digit; seconds wrap after 59

Ports:
clk         input   1  system clock, same clock as debouncers
rst_n       input   1  asynchronous, active-low reset
tick_1hz    input   1  one-clk-wide count enable, 1 Hz
tick_2hz    input   1  one-clk-wide adjust/blink enable, 2 Hz
pause_btn   input   1  debounced pause level; rising edge toggles STOP/RUN
clear_btn   input   1  debounced clear level, synchronous
adj_sw      input   1  debounced adjust-mode switch level
sel_sw      input   1  adjust field select: 0 = minutes, 1 = seconds
min_tens    output  4  BCD minutes tens
min_ones    output  4  BCD minutes ones
sec_tens    output  4  BCD seconds tens
sec_ones    output  4  BCD seconds ones
running     output  1  1 while FSM is in RUN
blank_min   output  1  1 = display blanks minutes field
blank_sec   output  1  1 = display blanks seconds field
rollover    output  1  one-clk pulse on 99:59 -> 00:00 in RUN

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. When rst_n=0, all registers clear immediately: state=STOP, all digits 0, pause_prev=0, blink_q=0, rollover=0, running=0, blank_min=blank_sec=0.
- Pause edge: pause_prev registers pause_btn. pause_edge = pause_btn & ~pause_prev. It acts on the same edge that loads pause_prev=1. A held button yields exactly one edge.
- FSM states: STOP, RUN, ADJ. Priority per edge, highest first:
  1. clear_btn=1: state<=STOP, all digits<=0, blink_q<=0. Held clear keeps 00:00 and STOP. adj_sw is ignored while clear is high.
  2. adj_sw=1: state<=ADJ from any state.
  3. ADJ with adj_sw=0: state<=STOP. ADJ never resumes RUN.
  4. STOP with pause_edge: RUN. RUN with pause_edge: STOP. pause_edge in ADJ is ignored.
- Counting: only when the current (pre-update) state is RUN and tick_1hz=1. The digits update on that edge.
  - A tick coinciding with the pause_edge that stops the watch still counts.
  - A tick coinciding with the edge that starts the watch does not count.
- Carry chain: sec_ones 9->0 carries to sec_tens. sec_tens SEC_TENS_MAX with sec_ones 9 -> both 0, carry to min_ones. min_ones 9->0 carries to min_tens. At MAX_MIN_TENS:9:5:9 all digits go to 0 and rollover=1 for exactly one clk. Counting continues after the wrap.
- Adjust: in ADJ on tick_2hz, increment only the field chosen by the current sel_sw. There is no carry between fields.
  - Seconds wrap 59->00, minutes wrap 99->00. rollover stays 0.
  - tick_1hz is ignored in ADJ.
- Blink: blink_q toggles on tick_2hz while in ADJ and clears on leaving ADJ.
  - blank_min = ADJ & ~sel_sw & blink_q.
  - blank_sec = ADJ & sel_sw & blink_q.
  - An incrementing tick also toggles blink, so the field reappears with its new value on alternate ticks.
- running = (state==RUN), registered, so it reflects the state after each edge.
- All outputs are registered. Digits are never outside the BCD range 0-9, or 0-SEC_TENS_MAX for sec_tens.
- Reset mid-count or mid-adjust: immediate clear with no partial update.

Decomposition:
- Shared package: state encoding (STOP=2'd0, RUN=2'd1, ADJ=2'd2) and the BCD digit limit constants, shared with the display driver.
- One sub-module, bcd_field_counter:
  - Parameters: TENS_MAX, ONES_MAX.
  - Inputs: inc, clr.
  - Outputs: tens, ones, and a wrap flag.
  - Instantiated twice, for seconds (5,9) and minutes (MAX_MIN_TENS,9).
  - wrap from seconds gates inc of minutes in RUN only.

Test Plan:
- Reset, pause_btn rise, 60 tick_1hz pulses -> running=1, display 01:00. 60 more ticks with pause_btn held high -> 02:00 (single toggle).
- Preload 99:58 via ADJ, exit, start, 2 ticks -> 99:59, then 00:00 with rollover high exactly one clk and running still 1.
- At 00:37 in RUN, assert tick_1hz and pause edge in the same cycle -> 00:38, running=0. Further ticks -> remains 00:38.
- adj_sw=1, sel_sw=1 from 00:58, 3 tick_2hz -> 00:59, 00:00, 00:01 with min unchanged. blank_sec toggles 1,0,1 and blank_min stays 0. Then adj_sw=0 -> STOP, blanks 0.
- RUN at 12:34 with clear_btn=1 for 5 clks while tick_1hz and adj_sw pulse -> 00:00, state STOP throughout, running=0.
- Drive rst_n low asynchronously between clk edges during ADJ -> all outputs 0 immediately. After release, tick_2hz has no effect until adj_sw is asserted.
